q2_serial_exec: RTL and testbench
=================================

# q2_serial_exec

Parametrised bit-serial execution unit: the next-generation arithmetic/logic engine for the q2 family, generalised from the fixed 12-bit serial ALU path to an arbitrary `WIDTH` with eight operations, a persistent carry flag and a start/done handshake. It loads two operands in parallel and computes the result LSB-first, one bit per clock. Each result bit is shifted into the accumulator MSB, the same right-shifting accumulator scheme the q2 slices use. It sits between the control sequencer and the A/X register file.

## Interface
Parameters:
- `WIDTH`, default 12: operand/result width; legal range 2..32.

Ports:
- `clk` in 1: single system clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: request an operation; sampled only in IDLE or DONE.
- `op` in 3: operation code, captured with `start`.
- `a_in` in WIDTH: accumulator operand, captured with `start`.
- `x_in` in WIDTH: second operand, captured with `start`.
- `busy` out 1: high while bits are being computed (RUN).
- `done` out 1: one-cycle pulse when the result is valid.
- `result` out WIDTH: accumulator contents; valid from `done` until the next accepted `start`.
- `c` out 1: carry flag.
- `z` out 1: zero flag of the last completed result.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE/DONE with `start`=1 -> RUN. Loads `a_in` and `x_in` into the shift registers and latches `op`. Bit counter = 0, running carry = operation's carry-in, running zero = 1.
  - RUN: each cycle computes bit i from `a_sh[0]`, `x_sh[0]` and the running carry. Shifts `a_sh` right with the new bit entering at MSB, shifts `x_sh` right, then increments the counter. After the WIDTH-th bit -> DONE.
  - DONE lasts exactly one cycle. With `start`=0 -> IDLE; with `start`=1 -> RUN (back-to-back operations allowed).
- Opcodes (carry-in; effect on `c`):
  - 000 ADD: a+x; cin 0; `c` = carry out.
  - 001 ADC: a+x+c; cin `c`; `c` = carry out.
  - 010 SUB: a+~x+1; cin 1; `c` = carry out (1 = no borrow).
  - 011 AND; 100 OR; 101 XOR; 110 NOR. `c` unchanged for all four.
  - 111 SHR: result = {c, a[WIDTH-1:1]}; `c` = a[0].
    - Serially: bits 0..WIDTH-2 take `a_sh[1]`, the MSB takes the latched `c`.
    - Original a[0] is held at start for the new `c`.
- Flag and width rules:
  - `c` updates only at the RUN->DONE transition; it holds across IDLE.
  - `z` = NOR of all result bits, updated at RUN->DONE.
  - Arithmetic is modulo 2^WIDTH. The counter is $clog2(WIDTH) bits and wraps to 0 on completion.
- `start` while in RUN is ignored; operands and `op` are not recaptured.
- `op` and operand inputs may change freely after the capture cycle.

## Timing
- Start accepted at rising edge T, so `busy`=1 for cycles T+1..T+WIDTH.
- `done`=1 and `result`, `c`, `z` valid in cycle T+WIDTH+1.
- Start-to-done latency is WIDTH+1 clocks (13 for WIDTH=12). Throughput is one operation per WIDTH+1 clocks when back-to-back.
- `result` shows partial shifted contents during RUN; consumers must qualify with `done`.
- Reset values when `rst`=0, asynchronously and regardless of state:
  - state IDLE, `busy`=0, `done`=0;
  - `result`=0, `c`=0, `z`=1, counter=0.
- Reset mid-RUN aborts the operation and produces no `done`.
- Release of `rst` is synchronised to `clk` in the integration wrapper. The block assumes a clean deassertion.

## Test plan
- ADD, WIDTH=12, a=0x005, x=0x003 -> `done` exactly 13 cycles after start, `result`=0x008, `c`=0, `z`=0; `busy` high for exactly 12 cycles.
- SUB a=0x005, x=0x005 -> `result`=0x000, `c`=1, `z`=1. Then SUB a=0x003, x=0x005 -> `result`=0xFFE, `c`=0.
- Carry chain: ADD 0xFFF+0x001 -> 0x000, `c`=1. Then back-to-back ADC 0x000+0x000 (start asserted in the DONE cycle) -> 0x001, `c`=0, `done` 13 cycles later.
- SHR with `c`=1, a=0x002 -> 0x801, `c`=0. Then AND 0xF0F & 0x0FF -> 0x00F with `c` unchanged; NOR 0xFFF,0x000 -> 0x000, `z`=1.
- Protocol: `start` pulsed at RUN cycle 5 with different operands -> ignored, original result returned. Then `rst` low at RUN cycle 6 -> immediate IDLE, `result`=0, `c`=0, `z`=1, no `done` pulse.
- WIDTH=16 instance: ADD 0xFFFF+0x0001 -> 0x0000, `c`=1, `z`=1, `done` 17 cycles after start.

Source files
------------

// File: rtl/q2_serial_exec.sv
// Bit-serial ALU: operands are loaded in parallel, the result is formed LSB-first
// and shifted into the accumulator MSB, one bit per clock, with persistent carry/zero flags.
module q2_serial_exec #(
  parameter int unsigned WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] x_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c,
  output logic             z
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_ADC = 3'b001, OP_SUB = 3'b010, OP_AND = 3'b011,
    OP_OR  = 3'b100, OP_XOR = 3'b101, OP_NOR = 3'b110, OP_SHR = 3'b111
  } op_t;

  state_t           state_q;
  op_t              op_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] x_sh_q;
  logic [CW-1:0]    cnt_q;
  logic             cy_q;
  logic             zr_q;
  logic             a0_q;
  logic             c_q;
  logic             z_q;
  logic             busy_q;
  logic             done_q;

  logic             bit_d;
  logic             cout_d;
  logic             last_bit;
  logic             a_b;
  logic             x_b;

  assign last_bit = (cnt_q == CW'(WIDTH - 1));
  assign a_b      = a_sh_q[0];

  always_comb begin
    bit_d  = 1'b0;
    cout_d = cy_q;
    x_b    = x_sh_q[0];
    case (op_q)
      OP_ADD, OP_ADC, OP_SUB: begin
        if (op_q == OP_SUB) x_b = ~x_sh_q[0];
        bit_d  = a_b ^ x_b ^ cy_q;
        cout_d = (a_b & x_b) | (cy_q & (a_b ^ x_b));
      end
      OP_AND: bit_d = a_b & x_b;
      OP_OR:  bit_d = a_b | x_b;
      OP_XOR: bit_d = a_b ^ x_b;
      OP_NOR: bit_d = ~(a_b | x_b);
      // a_sh[1] is always the next-higher original bit; the MSB slot takes the old carry
      OP_SHR: bit_d = last_bit ? c_q : a_sh_q[1];
      default: bit_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_ADD;
      a_sh_q  <= '0;
      x_sh_q  <= '0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      zr_q    <= 1'b1;
      a0_q    <= 1'b0;
      c_q     <= 1'b0;
      z_q     <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
            op_q    <= op_t'(op);
            a_sh_q  <= a_in;
            x_sh_q  <= x_in;
            a0_q    <= a_in[0];
            cnt_q   <= '0;
            zr_q    <= 1'b1;
            cy_q    <= (op == OP_ADC) ? c_q : (op == OP_SUB);
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          a_sh_q <= {bit_d, a_sh_q[WIDTH-1:1]};
          x_sh_q <= {1'b0, x_sh_q[WIDTH-1:1]};
          cy_q   <= cout_d;
          zr_q   <= zr_q & ~bit_d;
          if (last_bit) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            cnt_q   <= '0;
            z_q     <= zr_q & ~bit_d;
            case (op_q)
              OP_ADD, OP_ADC, OP_SUB: c_q <= cout_d;
              OP_SHR:                 c_q <= a0_q;
              default:                c_q <= c_q;
            endcase
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = a_sh_q;
  assign c      = c_q;
  assign z      = z_q;

endmodule

// File: tb/tb_q2_serial_exec.sv
// Directed self-checking bench for q2_serial_exec (WIDTH=12 and WIDTH=16 instances).
module tb_q2_serial_exec;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        start12 = 1'b0;
  logic [2:0]  op12 = 3'd0;
  logic [11:0] a12 = '0, x12 = '0;
  logic        busy12, done12, c12, z12;
  logic [11:0] res12;

  logic        start16 = 1'b0;
  logic [2:0]  op16 = 3'd0;
  logic [15:0] a16 = '0, x16 = '0;
  logic        busy16, done16, c16, z16;
  logic [15:0] res16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  q2_serial_exec #(.WIDTH(12)) dut12 (
    .clk(clk), .rst(rst), .start(start12), .op(op12), .a_in(a12), .x_in(x12),
    .busy(busy12), .done(done12), .result(res12), .c(c12), .z(z12)
  );

  q2_serial_exec #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .op(op16), .a_in(a16), .x_in(x16),
    .busy(busy16), .done(done16), .result(res16), .c(c16), .z(z16)
  );

  // Waits (bounded) for done; lat is the cycle index after the accepting edge (1 = first RUN cycle).
  task automatic wait_done12(input int lat0, input int bcnt0, output int lat, output int bcnt);
    lat = lat0; bcnt = bcnt0;
    while (!done12 && lat < 60) begin
      if (busy12) bcnt++;
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic run12(input logic [2:0] o, input logic [11:0] a, input logic [11:0] x,
                       output int lat, output int bcnt);
    @(negedge clk);
    op12 = o; a12 = a; x12 = x; start12 = 1'b1;
    @(posedge clk); #1;
    start12 = 1'b0;
    wait_done12(1, 0, lat, bcnt);
  endtask

  task automatic test_reset;
    int lat, bcnt;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy12 !== 1'b0)   begin errors++; $display("FAIL reset_busy got %b exp 0", busy12); end
    checks++; if (done12 !== 1'b0)   begin errors++; $display("FAIL reset_done got %b exp 0", done12); end
    checks++; if (res12 !== 12'h000) begin errors++; $display("FAIL reset_result got %h exp 000", res12); end
    checks++; if (c12 !== 1'b0)      begin errors++; $display("FAIL reset_c got %b exp 0", c12); end
    checks++; if (z12 !== 1'b1)      begin errors++; $display("FAIL reset_z got %b exp 1", z12); end
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy12 !== 1'b0 || done12 !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset busy=%b done=%b exp 0/0", busy12, done12);
    end
  endtask

  task automatic test_add;
    int lat, bcnt;
    run12(3'b000, 12'h005, 12'h003, lat, bcnt);
    checks++; if (lat !== 13)        begin errors++; $display("FAIL add_latency got %0d exp 13", lat); end
    checks++; if (bcnt !== 12)       begin errors++; $display("FAIL add_busy_cycles got %0d exp 12", bcnt); end
    checks++; if (res12 !== 12'h008) begin errors++; $display("FAIL add_result got %h exp 008", res12); end
    checks++; if (c12 !== 1'b0)      begin errors++; $display("FAIL add_c got %b exp 0", c12); end
    checks++; if (z12 !== 1'b0)      begin errors++; $display("FAIL add_z got %b exp 0", z12); end
    @(posedge clk); #1;
    checks++; if (done12 !== 1'b0)   begin errors++; $display("FAIL add_done_pulse got %b exp 0", done12); end
    checks++; if (res12 !== 12'h008) begin errors++; $display("FAIL add_result_hold got %h exp 008", res12); end
  endtask

  task automatic test_sub;
    int lat, bcnt;
    run12(3'b010, 12'h005, 12'h005, lat, bcnt);
    checks++; if (res12 !== 12'h000) begin errors++; $display("FAIL sub_eq_result got %h exp 000", res12); end
    checks++; if (c12 !== 1'b1)      begin errors++; $display("FAIL sub_eq_c got %b exp 1", c12); end
    checks++; if (z12 !== 1'b1)      begin errors++; $display("FAIL sub_eq_z got %b exp 1", z12); end
    run12(3'b010, 12'h003, 12'h005, lat, bcnt);
    checks++; if (res12 !== 12'hFFE) begin errors++; $display("FAIL sub_borrow_result got %h exp ffe", res12); end
    checks++; if (c12 !== 1'b0)      begin errors++; $display("FAIL sub_borrow_c got %b exp 0", c12); end
    checks++; if (z12 !== 1'b0)      begin errors++; $display("FAIL sub_borrow_z got %b exp 0", z12); end
  endtask

  task automatic test_back_to_back;
    int lat, bcnt;
    run12(3'b000, 12'hFFF, 12'h001, lat, bcnt);
    checks++; if (res12 !== 12'h000 || c12 !== 1'b1) begin
      errors++; $display("FAIL carry_add got %h c=%b exp 000 c=1", res12, c12);
    end
    // still in the DONE cycle: request the next op immediately
    op12 = 3'b001; a12 = 12'h000; x12 = 12'h000; start12 = 1'b1;
    @(posedge clk); #1;
    start12 = 1'b0;
    wait_done12(1, 0, lat, bcnt);
    checks++; if (lat !== 13)        begin errors++; $display("FAIL b2b_latency got %0d exp 13", lat); end
    checks++; if (res12 !== 12'h001) begin errors++; $display("FAIL b2b_adc_result got %h exp 001", res12); end
    checks++; if (c12 !== 1'b0)      begin errors++; $display("FAIL b2b_adc_c got %b exp 0", c12); end
  endtask

  task automatic test_shr_logic;
    int lat, bcnt;
    run12(3'b000, 12'hFFF, 12'h001, lat, bcnt);
    run12(3'b111, 12'h002, 12'h000, lat, bcnt);
    checks++; if (res12 !== 12'h801) begin errors++; $display("FAIL shr_result got %h exp 801", res12); end
    checks++; if (c12 !== 1'b0)      begin errors++; $display("FAIL shr_c got %b exp 0", c12); end
    run12(3'b011, 12'hF0F, 12'h0FF, lat, bcnt);
    checks++; if (res12 !== 12'h00F || c12 !== 1'b0) begin
      errors++; $display("FAIL and got %h c=%b exp 00f c=0", res12, c12);
    end
    run12(3'b000, 12'hFFF, 12'h001, lat, bcnt);
    run12(3'b100, 12'h0A0, 12'h005, lat, bcnt);
    checks++; if (res12 !== 12'h0A5 || c12 !== 1'b1) begin
      errors++; $display("FAIL or got %h c=%b exp 0a5 c=1", res12, c12);
    end
    run12(3'b101, 12'hFF0, 12'h0FF, lat, bcnt);
    checks++; if (res12 !== 12'hF0F || c12 !== 1'b1) begin
      errors++; $display("FAIL xor got %h c=%b exp f0f c=1", res12, c12);
    end
    run12(3'b110, 12'hFFF, 12'h000, lat, bcnt);
    checks++; if (res12 !== 12'h000 || z12 !== 1'b1 || c12 !== 1'b1) begin
      errors++; $display("FAIL nor got %h z=%b c=%b exp 000 z=1 c=1", res12, z12, c12);
    end
  endtask

  task automatic test_protocol;
    int lat, bcnt, dcnt, bsy;
    @(negedge clk);
    op12 = 3'b000; a12 = 12'h005; x12 = 12'h003; start12 = 1'b1;
    @(posedge clk); #1;
    start12 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    op12 = 3'b010; a12 = 12'hFFF; x12 = 12'hFFF; start12 = 1'b1;
    @(posedge clk); #1;
    start12 = 1'b0;
    wait_done12(6, 0, lat, bcnt);
    checks++; if (lat !== 13)        begin errors++; $display("FAIL ignore_start_latency got %0d exp 13", lat); end
    checks++; if (res12 !== 12'h008 || c12 !== 1'b0) begin
      errors++; $display("FAIL ignore_start_result got %h c=%b exp 008 c=0", res12, c12);
    end

    run12(3'b000, 12'hFFF, 12'h001, lat, bcnt);
    @(negedge clk);
    op12 = 3'b000; a12 = 12'h123; x12 = 12'h456; start12 = 1'b1;
    @(posedge clk); #1;
    start12 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++; if (busy12 !== 1'b0 || done12 !== 1'b0) begin
      errors++; $display("FAIL midrun_reset_busy_done got %b/%b exp 0/0", busy12, done12);
    end
    checks++; if (res12 !== 12'h000 || c12 !== 1'b0 || z12 !== 1'b1) begin
      errors++; $display("FAIL midrun_reset_state got %h c=%b z=%b exp 000 c=0 z=1", res12, c12, z12);
    end
    @(negedge clk); rst = 1'b1;
    dcnt = 0; bsy = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done12) dcnt++;
      if (busy12) bsy++;
    end
    checks++; if (dcnt !== 0 || bsy !== 0) begin
      errors++; $display("FAIL midrun_reset_no_done done=%0d busy=%0d exp 0/0", dcnt, bsy);
    end
  endtask

  task automatic test_width16;
    int lat;
    @(negedge clk);
    op16 = 3'b000; a16 = 16'hFFFF; x16 = 16'h0001; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    lat = 1;
    while (!done16 && lat < 60) begin
      @(posedge clk); #1; lat++;
    end
    checks++; if (lat !== 17)          begin errors++; $display("FAIL w16_latency got %0d exp 17", lat); end
    checks++; if (res16 !== 16'h0000)  begin errors++; $display("FAIL w16_result got %h exp 0000", res16); end
    checks++; if (c16 !== 1'b1 || z16 !== 1'b1) begin
      errors++; $display("FAIL w16_flags c=%b z=%b exp 1/1", c16, z16);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_shr_logic();
    test_protocol();
    test_width16();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
